// File: rtl/paddle_ctrl.sv
// Paddle position controller: synchronises and debounces the up/down buttons,
// then moves the paddle once per frame tick with hold-based acceleration and clamping.
module paddle_ctrl #(
   parameter int SCREEN_HEIGHT   = 480,
   parameter int PADDLE_HEIGHT   = 100,
   parameter int SPEED_MIN       = 2,
   parameter int SPEED_MAX       = 6,
   parameter int ACCEL_FRAMES    = 15,
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_tick,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       recenter,
   output logic [9:0] pad_top_pixel,
   output logic       at_top,
   output logic       at_bottom
);

   localparam int MAX_TOP = SCREEN_HEIGHT - PADDLE_HEIGHT;
   localparam int CENTER  = MAX_TOP / 2;
   localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int HOLD_W  = (ACCEL_FRAMES > 0) ? $clog2(ACCEL_FRAMES + 1) : 1;

   localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX    = HOLD_W'(ACCEL_FRAMES);
   localparam logic [10:0]       MAX_TOP_W   = 11'(MAX_TOP);
   localparam logic [9:0]        MAX_TOP_P   = 10'(MAX_TOP);
   localparam logic [9:0]        CENTER_P    = 10'(CENTER);
   localparam logic [10:0]       SPEED_MIN_W = 11'(SPEED_MIN);
   localparam logic [10:0]       SPEED_MAX_W = 11'(SPEED_MAX);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      UP   = 2'd1,
      DOWN = 2'd2
   } state_t;

   logic [1:0] btn_raw;
   logic [1:0] btn_db;

   assign btn_raw = {btn_down, btn_up};

   // Bit 0 is the up button, bit 1 the down button.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_btn
         logic            sync0_reg;
         logic            sync1_reg;
         logic            db_reg;
         logic [DB_W-1:0] cnt_reg;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sync0_reg <= 1'b0;
               sync1_reg <= 1'b0;
               db_reg    <= 1'b0;
               cnt_reg   <= '0;
            end else begin
               sync0_reg <= btn_raw[gi];
               sync1_reg <= sync0_reg;
               if (sync1_reg == db_reg) begin
                  cnt_reg <= '0;
               end else if (cnt_reg == DB_LAST) begin
                  db_reg  <= sync1_reg;
                  cnt_reg <= '0;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
         end

         assign btn_db[gi] = db_reg;
      end
   endgenerate

   state_t              state_reg, state_next;
   state_t              req;
   logic [HOLD_W-1:0]   hold_cnt_reg, hold_cnt_next;
   logic [9:0]          pos_reg, pos_next;
   logic [10:0]         pos_ext;
   logic [10:0]         step;
   logic [10:0]         sum;
   logic                same_dir;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         hold_cnt_reg <= '0;
         pos_reg      <= CENTER_P;
      end else begin
         state_reg    <= state_next;
         hold_cnt_reg <= hold_cnt_next;
         pos_reg      <= pos_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      hold_cnt_next = hold_cnt_reg;
      pos_next      = pos_reg;
      pos_ext       = {1'b0, pos_reg};
      step          = SPEED_MIN_W;
      sum           = pos_ext + SPEED_MIN_W;
      same_dir      = 1'b0;

      if (btn_db[0] && !btn_db[1]) begin
         req = UP;
      end else if (btn_db[1] && !btn_db[0]) begin
         req = DOWN;
      end else begin
         req = IDLE;
      end

      // recenter wins over a coincident frame tick.
      if (recenter) begin
         pos_next      = CENTER_P;
         state_next    = IDLE;
         hold_cnt_next = '0;
      end else if (frame_tick) begin
         if (req == IDLE) begin
            state_next    = IDLE;
            hold_cnt_next = '0;
         end else begin
            same_dir = (req == state_reg);
            if (same_dir && hold_cnt_reg == HOLD_MAX) begin
               step = SPEED_MAX_W;
            end
            if (!same_dir) begin
               hold_cnt_next = '0;
            end else if (hold_cnt_reg != HOLD_MAX) begin
               hold_cnt_next = hold_cnt_reg + 1'b1;
            end
            state_next = req;
            sum        = pos_ext + step;
            if (req == UP) begin
               pos_next = (pos_ext < step) ? 10'd0 : 10'(pos_ext - step);
            end else begin
               pos_next = (sum > MAX_TOP_W) ? MAX_TOP_P : sum[9:0];
            end
         end
      end
   end

   assign pad_top_pixel = pos_reg;
   assign at_top        = (pos_reg == 10'd0);
   assign at_bottom     = (pos_reg == MAX_TOP_P);

endmodule

// File: doc/paddle_ctrl.md
Name: paddle_ctrl

Overview:
- Produces the paddle top-pixel position consumed by the paddle renderer. This is the writer side of the `pad_top_pixel` interface.
- Inputs: raw up/down push-buttons. They are synchronised and debounced, then the paddle is moved once per video frame, with acceleration after a sustained hold.
- The position is always clamped so the full paddle stays on the 480-line visible area.
- Updates only on the frame tick (vertical blank) so the drawn paddle never tears mid-frame.

Parameters:
- SCREEN_HEIGHT, 480, visible lines.
- PADDLE_HEIGHT, 100, paddle height in lines; must match the renderer.
- SPEED_MIN, 2, lines per frame at start of a hold.
- SPEED_MAX, 6, lines per frame after acceleration.
- ACCEL_FRAMES, 15, consecutive same-direction frames before SPEED_MAX applies.
- DEBOUNCE_CYCLES, 250000, stable clk cycles required to accept a button change (10 ms at 25 MHz).

Ports:
- clk  input  1  pixel clock.
- rst_n  input  1  asynchronous active-low reset.
- frame_tick  input  1  one-cycle pulse per frame, asserted in vertical blank.
- btn_up  input  1  raw, asynchronous, active-high.
- btn_down  input  1  raw, asynchronous, active-high.
- recenter  input  1  synchronous, one-cycle request to return the paddle to centre.
- pad_top_pixel  output  10  paddle top line, registered.
- at_top  output  1  high when pad_top_pixel == 0.
- at_bottom  output  1  high when pad_top_pixel == MAX_TOP.

Behaviour:
- Derived constants:
  - MAX_TOP = SCREEN_HEIGHT - PADDLE_HEIGHT (380).
  - CENTER = MAX_TOP / 2 (190).
- Reset (async, rst_n low):
  - pad_top_pixel = CENTER.
  - FSM = IDLE, hold_cnt = 0.
  - Synchroniser flops = 0, debounced buttons = 0, debounce counters = 0.
  - at_top = 0, at_bottom = 0.
  - Reset asserted mid-move aborts the move immediately.
- Synchroniser: 2 flops per button.
- Debounce, per button:
  - The counter increments while the synced value differs from the debounced value.
  - It clears whenever the two are equal.
  - When the count reaches DEBOUNCE_CYCLES-1, the debounced value flips and the counter clears.
  - Pulses shorter than DEBOUNCE_CYCLES are never accepted.
- FSM states: IDLE, UP, DOWN. State changes only on frame_tick.
- Requested direction:
  - UP if db_up & ~db_down.
  - DOWN if db_down & ~db_up.
  - Otherwise IDLE (both or neither pressed).
- On frame_tick with a non-IDLE request:
  - step = SPEED_MAX if request == current state and hold_cnt == ACCEL_FRAMES; otherwise SPEED_MIN.
  - hold_cnt <= (request == current state) ? min(hold_cnt+1, ACCEL_FRAMES) : 0.
  - State <= request.
- On frame_tick with an IDLE request: state <= IDLE, hold_cnt <= 0, position unchanged.
- Arithmetic, done in 11 bits:
  - UP: pos <= (pos < step) ? 0 : pos - step.
  - DOWN: pos <= (pos + step > MAX_TOP) ? MAX_TOP : pos + step.
  - pad_top_pixel never leaves [0, MAX_TOP].
- A direction reversal takes effect at the next tick with SPEED_MIN; there is no deceleration phase.
- recenter has priority over frame_tick in the same cycle:
  - pos <= CENTER, state <= IDLE, hold_cnt <= 0.
  - Debouncers are unaffected.
- Latency:
  - pad_top_pixel updates on the clk edge after the cycle in which frame_tick or recenter is high.
  - At no other time does it change.
- at_top and at_bottom are decoded from the pos register and carry the same one-cycle latency.
- A button press becomes effective at the first frame_tick after its debounce completes.

Test Plan:
- Reset: assert rst_n=0 mid-simulation -> pad_top_pixel=190 asynchronously; at_top=0, at_bottom=0; no movement on subsequent ticks with buttons released.
- Up movement (DEBOUNCE_CYCLES=4, ACCEL_FRAMES=3): hold btn_up, issue 3 frame_ticks after debounce -> pad_top_pixel 188, 186, 184; unchanged between ticks.
- Acceleration (ACCEL_FRAMES=3): from 190, hold btn_down for 6 ticks -> 192, 194, 196, 198, 204, 210; release, then 1 tick -> stays 210, next press restarts at step 2.
- Clamp: hold btn_up for 200 ticks -> reaches 0 and stays 0, at_top=1; hold btn_down for 200 ticks -> reaches 380 and never exceeds it, at_bottom=1.
- Debounce and conflict:
  - 3-cycle glitch on btn_up (DEBOUNCE_CYCLES=4) then tick -> no change.
  - Both buttons held for 5 ticks -> no change, FSM stays IDLE.
- recenter: while moving down at SPEED_MAX, assert recenter in the same cycle as frame_tick -> next cycle pad_top_pixel=190; the following tick moves by SPEED_MIN (192).
